// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory: boot-load stream, then byte-addressed
// fetches with one-cycle latency, stall hold and error flagging.
module instr_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              boot_start,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    output logic              booted
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] ld_idx;
    logic [IDX_W-1:0] f_idx;
    logic             ld_ok;
    logic             f_ok;
    logic             ld_we;
    logic             accept;

    assign ld_idx = ld_addr[IDX_W+1:2];
    assign f_idx  = fetch_addr[IDX_W+1:2];
    assign ld_ok  = (ld_addr < LIMIT) && (ld_addr[1:0] == 2'b00);
    assign f_ok   = (fetch_addr < LIMIT) && (fetch_addr[1:0] == 2'b00);
    assign ld_we  = (state == BOOT) && ld_valid && ld_ok;

    // Ready only in RUN, not while holding a stalled result, not on reboot
    assign fetch_ready = (state == RUN)
                       && !(fetch_valid && fetch_stall)
                       && !boot_start;
    assign accept = fetch_req && fetch_ready;

    // Program storage; no reset, written only by the boot stream
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Boot/run sequencing and the registered fetch result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            booted      <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_err   <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    fetch_valid <= 1'b0;
                    if (ld_done) begin
                        state  <= RUN;
                        booted <= 1'b1;
                    end
                end
                RUN: begin
                    if (boot_start) begin
                        state       <= BOOT;
                        booted      <= 1'b0;
                        fetch_valid <= 1'b0;
                    end else if (accept) begin
                        fetch_valid <= 1'b1;
                        fetch_instr <= f_ok ? mem[f_idx] : '0;
                        fetch_err   <= !f_ok;
                    end else if (!(fetch_valid && fetch_stall)) begin
                        fetch_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed self-checking bench for instr_mem_ctrl.
// Inputs change on the falling edge; outputs are checked there too.
module tb_instr_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        boot_start;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        booted;

    int checks = 0;
    int errors = 0;

    instr_mem_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ld_valid(ld_valid),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ld_done(ld_done),
        .boot_start(boot_start),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_err(fetch_err),
        .booted(booted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load(input logic [31:0] a, input logic [31:0] d,
                        input logic done);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_done  = done;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b exp 0", fetch_valid);
        end
        checks++;
        if (fetch_instr !== 32'h0) begin
            errors++;
            $display("FAIL rst_instr got %h exp 0", fetch_instr);
        end
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_err got %b exp 0", fetch_err);
        end
        checks++;
        if (booted !== 1'b0) begin
            errors++;
            $display("FAIL rst_booted got %b exp 0", booted);
        end
        checks++;
        if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got %b exp 0", fetch_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_boot_fetch();
        logic [31:0] exp [3];
        exp[0] = 32'h8C000000;
        exp[1] = 32'h8C040000;
        exp[2] = 32'h20010005;
        load(32'h00, exp[0], 1'b0);
        load(32'h04, exp[1], 1'b0);
        load(32'h08, exp[2], 1'b0);
        checks++;
        if (booted !== 1'b0) begin
            errors++;
            $display("FAIL boot_booted got %b exp 0", booted);
        end
        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        checks++;
        if (booted !== 1'b1) begin
            errors++;
            $display("FAIL run_booted got %b exp 1", booted);
        end
        for (int i = 0; i < 3; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'(i * 4);
            #1;
            checks++;
            if (fetch_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d got %b exp 1", i, fetch_ready);
            end
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b1 || fetch_instr !== exp[i] ||
                fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d got v%b %h e%b exp v1 %h e0",
                         i, fetch_valid, fetch_instr, fetch_err, exp[i]);
            end
        end
        fetch_req = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b0 || fetch_instr !== exp[2]) begin
            errors++;
            $display("FAIL idle_hold got v%b %h exp v0 %h",
                     fetch_valid, fetch_instr, exp[2]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [2];
        addrs[0] = 32'h06;
        addrs[1] = 32'h100;
        for (int i = 0; i < 2; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = addrs[i];
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0 ||
                fetch_err !== 1'b1) begin
                errors++;
                $display("FAIL err_%h got v%b %h e%b exp v1 0 e1",
                         addrs[i], fetch_valid, fetch_instr, fetch_err);
            end
        end
        fetch_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        fetch_req  = 1'b1;
        fetch_addr = 32'h04;
        @(negedge clk);
        fetch_stall = 1'b1;
        fetch_addr  = 32'h08;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fetch_ready !== 1'b0 || fetch_valid !== 1'b1 ||
                fetch_instr !== 32'h8C040000 || fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d got r%b v%b %h exp r0 v1 8c040000",
                         i, fetch_ready, fetch_valid, fetch_instr);
            end
            @(negedge clk);
        end
        fetch_stall = 1'b0;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_rel_ready got %b exp 1", fetch_ready);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        checks++;
        if (fetch_valid !== 1'b1 || fetch_instr !== 32'h20010005) begin
            errors++;
            $display("FAIL stall_rel got v%b %h exp v1 20010005",
                     fetch_valid, fetch_instr);
        end
        @(negedge clk);
    endtask

    task automatic test_run_load_ignored();
        load(32'h00, 32'hFFFFFFFF, 1'b1);
        fetch_req  = 1'b1;
        fetch_addr = 32'h00;
        @(negedge clk);
        fetch_req = 1'b0;
        checks++;
        if (fetch_instr !== 32'h8C000000 || booted !== 1'b1) begin
            errors++;
            $display("FAIL run_ld got %h b%b exp 8c000000 b1",
                     fetch_instr, booted);
        end
    endtask

    task automatic test_reboot();
        logic [31:0] exp [3];
        exp[0] = 32'h08000007;
        exp[1] = 32'h8C040000;
        exp[2] = 32'h20010005;
        fetch_req  = 1'b1;
        fetch_addr = 32'h00;
        @(negedge clk);
        boot_start = 1'b1;
        fetch_addr = 32'h04;
        #1;
        checks++;
        if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL rb_ready got %b exp 0", fetch_ready);
        end
        @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b0 || booted !== 1'b0) begin
            errors++;
            $display("FAIL rb_state got v%b b%b exp v0 b0",
                     fetch_valid, booted);
        end
        fetch_addr = 32'h00;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (fetch_ready !== 1'b0) begin
                errors++;
                $display("FAIL bg_ready%0d got %b exp 0", i, fetch_ready);
            end
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b0 || booted !== 1'b0) begin
                errors++;
                $display("FAIL bg_valid%0d got v%b b%b exp v0 b0",
                         i, fetch_valid, booted);
            end
        end
        boot_start = 1'b0;
        fetch_req  = 1'b0;
        load(32'h06,  32'h11111111, 1'b0);
        load(32'h104, 32'h22222222, 1'b0);
        load(32'h10A, 32'h33333333, 1'b0);
        load(32'h102, 32'h44444444, 1'b0);
        load(32'h00,  exp[0], 1'b1);
        checks++;
        if (booted !== 1'b1) begin
            errors++;
            $display("FAIL rl_booted got %b exp 1", booted);
        end
        for (int i = 0; i < 3; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'(i * 4);
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b1 || fetch_instr !== exp[i] ||
                fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL rl_%0d got v%b %h e%b exp v1 %h e0",
                         i, fetch_valid, fetch_instr, fetch_err, exp[i]);
            end
        end
        fetch_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        fetch_req  = 1'b1;
        fetch_addr = 32'h04;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 ||
            booted !== 1'b0 || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL arst got v%b %h b%b r%b exp v0 0 b0 r0",
                     fetch_valid, fetch_instr, booted, fetch_ready);
        end
        fetch_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        ld_done     = 1'b0;
        boot_start  = 1'b0;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;
        test_reset();
        test_boot_fetch();
        test_errors();
        test_stall();
        test_run_load_ignored();
        test_reboot();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
